// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer and HI/LO owner for the E stage.
// The result is computed combinationally when the op is accepted and
// parked in temporaries; a down-counter then models the fixed latency
// before HI/LO are updated, so consumers see the architectural timing.
module md_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        block,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_res_hi;
    logic [31:0]     r_res_lo;
    logic            r_res_wr;

    logic            w_accept;
    logic            w_is_mul;
    logic            w_is_div;
    logic            w_signed;
    logic            w_done;
    logic [63:0]     w_ma;
    logic [63:0]     w_mb;
    logic [63:0]     w_prod;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [31:0]     w_a_mag;
    logic [31:0]     w_b_mag;
    logic [31:0]     w_b_safe;
    logic [31:0]     w_q_mag;
    logic [31:0]     w_r_mag;
    logic [31:0]     w_quo;
    logic [31:0]     w_rem;

    assign w_accept = start && !block && (r_state == S_IDLE);
    assign w_is_mul = (op == 3'b000) || (op == 3'b001);
    assign w_is_div = (op == 3'b010) || (op == 3'b011);
    // Even codes of the mult/div group are the signed variants.
    assign w_signed = ~op[0];
    assign w_done   = (r_state == S_RUN) && (r_cnt == CW'(1));

    // Multiply: sign- or zero-extend to 64 bits, keep the low 64 of the product.
    assign w_ma   = w_signed ? {{32{a[31]}}, a} : {32'b0, a};
    assign w_mb   = w_signed ? {{32{b[31]}}, b} : {32'b0, b};
    assign w_prod = w_ma * w_mb;

    // Divide on magnitudes so INT_MIN / -1 falls out as 0x80000000 rem 0
    // without relying on signed-overflow behaviour of the divider.
    assign w_a_neg  = w_signed & a[31];
    assign w_b_neg  = w_signed & b[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - a) : a;
    assign w_b_mag  = w_b_neg ? (32'd0 - b) : b;
    // Divisor of zero is replaced so the datapath never divides by zero;
    // the result is discarded anyway (r_res_wr=0).
    assign w_b_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    assign w_quo    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: mult/div acceptance enters RUN, last counted cycle leaves it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && (w_is_mul || w_is_div)) w_state_nxt = S_RUN;
            S_RUN:  if (r_cnt == CW'(1))                    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latency counter: loaded on acceptance, decremented every RUN cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_accept && w_is_mul) begin
            r_cnt <= CW'(MULT_CYC);
        end else if (w_accept && w_is_div) begin
            r_cnt <= CW'(DIV_CYC);
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Result temporaries captured from the operands sampled at acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_res_wr <= 1'b0;
        end else if (w_accept && w_is_mul) begin
            r_res_hi <= w_prod[63:32];
            r_res_lo <= w_prod[31:0];
            r_res_wr <= 1'b1;
        end else if (w_accept && w_is_div) begin
            r_res_hi <= w_rem;
            r_res_lo <= w_quo;
            r_res_wr <= (b != 32'd0);
        end
    end

    // HI/LO: direct moves at acceptance, mult/div results on the final RUN edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (w_accept && (op == 3'b100)) begin
            hi <= a;
        end else if (w_accept && (op == 3'b101)) begin
            lo <= a;
        end else if (w_done && r_res_wr) begin
            hi <= r_res_hi;
            lo <= r_res_lo;
        end
    end

    assign busy  = (r_state == S_RUN);
    // Stall also covers the acceptance cycle so a dependent op in D cannot
    // slip into E one cycle before busy rises.
    assign stall = d_md_use && (busy || (start && !block && (op <= 3'b011)));

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed and randomized checks of md_ctrl against a
// behavioural model that computes results with plain 64-bit arithmetic.
module tb_md_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b0;
    logic        block = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        d_md_use = 1'b0;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    md_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .block(block),
        .a(a), .b(b), .d_md_use(d_md_use), .busy(busy), .stall(stall),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference model: busy length and resulting HI/LO for one request.
    task automatic model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                         input logic blk, output int n, output logic [31:0] nh,
                         output logic [31:0] nl);
        longint sp, sq, sr;
        longint unsigned up;
        logic [63:0] v, vr;
        n = 0; nh = exp_hi; nl = exp_lo;
        if (!blk) begin
            case (mop)
                3'd0: begin sp = longint'($signed(ma)) * longint'($signed(mb));
                            v = sp; nh = v[63:32]; nl = v[31:0]; n = MC; end
                3'd1: begin up = longint'({32'b0, ma}) * longint'({32'b0, mb});
                            v = up; nh = v[63:32]; nl = v[31:0]; n = MC; end
                3'd2: begin n = DC;
                            if (mb != 0) begin
                                sq = longint'($signed(ma)) / longint'($signed(mb));
                                sr = longint'($signed(ma)) % longint'($signed(mb));
                                v = sq; vr = sr; nl = v[31:0]; nh = vr[31:0];
                            end end
                3'd3: begin n = DC;
                            if (mb != 0) begin nl = ma / mb; nh = ma % mb; end end
                3'd4: nh = ma;
                3'd5: nl = ma;
                default: ;
            endcase
        end
    endtask

    // Issue one request and follow it cycle by cycle until it has retired.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                         input logic [31:0] vb, input logic blk, input logic use_d);
        int n;
        logic [31:0] nh, nl;
        logic es;
        model(o, va, vb, blk, n, nh, nl);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb; block = blk; d_md_use = use_d;
        #1;
        es = use_d && !blk && (o <= 3'd3);
        checks++;
        if (stall !== es) begin errors++;
            $display("FAIL %s accept-stall: got %b expected %b", tag, stall, es); end
        @(negedge clk);
        start = 1'b0; block = 1'b0; a = $urandom; b = $urandom;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (busy !== 1'b1 || hi !== exp_hi || lo !== exp_lo || stall !== use_d) begin
                errors++;
                $display("FAIL %s run cyc%0d: busy=%b stall=%b hi=%h lo=%h expected busy=1 stall=%b hi=%h lo=%h",
                         tag, i, busy, stall, hi, lo, use_d, exp_hi, exp_lo);
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0 || hi !== nh || lo !== nl) begin
            errors++;
            $display("FAIL %s done: busy=%b stall=%b hi=%h lo=%h expected busy=0 stall=0 hi=%h lo=%h",
                     tag, busy, stall, hi, lo, nh, nl);
        end
        d_md_use = 1'b0;
        exp_hi = nh; exp_lo = nl;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b stall=%b hi=%h lo=%h expected all zero", busy, stall, hi, lo);
        end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_mult();
        do_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        checks++;
        if (exp_hi !== 32'hFFFF_FFFF || exp_lo !== 32'hFFFF_FFFE) begin errors++;
            $display("FAIL mult-const: model hi=%h lo=%h", exp_hi, exp_lo); end
        do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        checks++;
        if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE) begin errors++;
            $display("FAIL multu-const: got hi=%h lo=%h expected 00000001 fffffffe", hi, lo); end
    endtask

    task automatic test_div();
        do_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin errors++;
            $display("FAIL div-neg: got hi=%h lo=%h expected ffffffff fffffffd", hi, lo); end
        do_op("div-ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checks++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000) begin errors++;
            $display("FAIL div-ovf: got hi=%h lo=%h expected 00000000 80000000", hi, lo); end
        do_op("mthi5", 3'd4, 32'd5, 32'd0, 1'b0, 1'b0);
        do_op("mtlo6", 3'd5, 32'd6, 32'd0, 1'b0, 1'b0);
        do_op("divu0", 3'd3, 32'd7, 32'd0, 1'b0, 1'b0);
        checks++;
        if (hi !== 32'd5 || lo !== 32'd6) begin errors++;
            $display("FAIL divu-zero: got hi=%h lo=%h expected 00000005 00000006", hi, lo); end
    endtask

    task automatic test_mthi_mtlo();
        do_op("mthi", 3'd4, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        do_op("mtlo", 3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin errors++;
            $display("FAIL mthi-mtlo: got hi=%h lo=%h expected 12345678 9abcdef0", hi, lo); end
        do_op("undef6", 3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0);
        do_op("undef7", 3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0);
    endtask

    task automatic test_block_stall();
        do_op("blocked-mult", 3'd0, 32'd3, 32'd4, 1'b1, 1'b1);
        do_op("stall-div", 3'd2, 32'd100, 32'd7, 1'b0, 1'b1);
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin errors++;
            $display("FAIL stall-div result: got hi=%h lo=%h expected 00000002 0000000e", hi, lo); end
    endtask

    // A mult issued while a div is running must be dropped entirely.
    task automatic test_drop();
        int n;
        logic [31:0] nh, nl;
        model(3'd3, 32'd1000, 32'd33, 1'b0, n, nh, nl);
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd33;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (busy !== 1'b1 || hi !== exp_hi || lo !== exp_lo) begin errors++;
                $display("FAIL drop run cyc%0d: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h",
                         i, busy, hi, lo, exp_hi, exp_lo); end
            if (i == 3) begin start = 1'b1; op = 3'd0; a = 32'h0001_0000; b = 32'h0001_0000; block = 1'b1; end
            else if (i == 4) begin block = 1'b0; end
            else begin start = 1'b0; end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || hi !== 32'd10 || lo !== 32'd30) begin errors++;
            $display("FAIL drop done: busy=%b hi=%h lo=%h expected busy=0 hi=0000000a lo=0000001e",
                     busy, hi, lo); end
        exp_hi = nh; exp_lo = nl;
    endtask

    task automatic test_reset_mid_run();
        do_op("pre-hi", 3'd4, 32'd1, 32'd0, 1'b0, 1'b0);
        do_op("pre-lo", 3'd5, 32'd2, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        reset = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++;
            $display("FAIL reset-mid: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo); end
        @(negedge clk); reset = 1'b1;
        exp_hi = '0; exp_lo = '0;
        for (int i = 0; i < MC + 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++;
                $display("FAIL reset-mid after cyc%0d: busy=%b hi=%h lo=%h expected 0 0 0", i, busy, hi, lo); end
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, rb;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 20);
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            do_op("random", 3'($urandom_range(0, 7)), ra, rb,
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_block_stall();
        test_drop();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multiply/divide sequencer and HI/LO register owner for the pipelined MIPS core.
- Sits in the E stage and accepts mult/multu/div/divu/mthi/mtlo, which the R-type decoder has already classified.
- Models fixed multi-cycle latency and holds the HI/LO results.
- Generates the pipeline stall request for any HI/LO-using instruction in D while an operation is pending.

Parameters:
- MULT_CYC, 5, busy cycles for mult/multu (>=1).
- DIV_CYC, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  E-stage op valid this cycle.
- op  input  3  operation code: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; other codes are no-ops.
- block  input  1  exception/interrupt in flight; suppresses acceptance of start this cycle.
- a  input  32  rs operand.
- b  input  32  rt operand.
- d_md_use  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  output  1  operation in progress.
- stall  output  1  stall request to hazard unit.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, busy=0, hi=0, lo=0, result temporaries=0. Reset wins over everything, including mid-operation; the operation in flight is discarded.
- States: IDLE, RUN.
- Accept condition: start=1 && block=0 && state==IDLE. Otherwise start is ignored with no state change. The hazard unit guarantees no start while busy; a start during RUN is dropped.
- mult/multu accepted in cycle T:
  - compute the 64-bit product (signed or unsigned) from a/b sampled at T into temporaries;
  - counter=MULT_CYC; state goes to RUN at the T edge;
  - busy=1 for cycles T+1..T+MULT_CYC;
  - on the edge ending cycle T+MULT_CYC: hi=prod[63:32], lo=prod[31:0], state goes to IDLE;
  - new values are visible, with busy=0, in cycle T+MULT_CYC+1.
- div/divu: same sequence as mult/multu with DIV_CYC.
  - lo=quotient, hi=remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
  - b==0: operation still occupies DIV_CYC busy cycles, and hi/lo are left unchanged at completion.
- mthi/mtlo: when accepted, hi (resp. lo) = a at the T edge. No busy cycles; state stays IDLE.
- Undefined op codes with start=1: no effect.
- Counter decrements once per RUN cycle. The transition RUN->IDLE occurs when counter==1 at the clock edge.
- busy = (state==RUN). It is registered and depends only on state.
- stall = d_md_use && (busy || (start && !block && op<=3'b011)). This covers the cycle in which a mult/div is being accepted.
- hi/lo hold their values while busy. Reads during RUN return the old values, but stall prevents a consumer from reaching E.
- block asserted during RUN has no effect; the operation completes. Only acceptance is suppressed by block.

Test Plan:
- reset=0 mid-RUN (mult in flight, hi/lo previously 1/2) -> hi=0, lo=0, busy=0 immediately, with no completion afterwards.
- mult a=0xFFFFFFFF b=2 at T -> busy=1 for T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFE. Repeat with multu -> hi=1, lo=0xFFFFFFFE.
- div a=-7 (0xFFFFFFF9) b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7 b=0 with prior hi=5, lo=6 -> 10 busy cycles, then hi=5, lo=6.
- mthi a=0x12345678, next cycle mtlo a=0x9ABCDEF0 -> hi=0x12345678 and lo=0x9ABCDEF0 one edge after each; busy stays 0.
- start=1 op=mult block=1 -> no busy, hi/lo unchanged. Separately: d_md_use=1 with start=1 op=div block=0 -> stall=1 that cycle and for all 10 busy cycles, stall=0 the cycle after.
- start=1 op=mult during RUN of a div -> ignored; div completes with its own result after exactly 10 cycles.
